// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer predictor.
// The BTB entry layout follows BP_XLEN / BP_TAG_BITS; the top-level XLEN and
// TAG_BITS parameters default to these and must be kept in step with them.
package bp_pkg;

  localparam int BP_XLEN     = 32;
  localparam int BP_TAG_BITS = 10;

  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_BITS-1:0] tag;
    logic [BP_XLEN-1:0]     target;
  } btb_entry_t;

  // Largest value a counter of the given width can hold.
  function automatic int unsigned ctr_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  // Weakly-not-taken: the highest value whose MSB is still clear.
  function automatic int unsigned ctr_wnt(input int unsigned bits);
    return (32'd1 << (bits - 32'd1)) - 32'd1;
  endfunction

  // Weakly-taken: the lowest value whose MSB is set.
  function automatic int unsigned ctr_wt(input int unsigned bits);
    return 32'd1 << (bits - 32'd1);
  endfunction

  // Saturating increment, clamped at the counter maximum.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned bits);
    return (v >= ctr_max(bits)) ? ctr_max(bits) : v + 32'd1;
  endfunction

  // Saturating decrement, clamped at zero.
  function automatic int unsigned sat_dec(input int unsigned v, input int unsigned bits);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/bp_btb_array.sv
// Direct-mapped BTB storage: a resettable valid vector plus tag/target
// arrays that need no reset. One fetch read port, one lookup read port for
// resolving branches, and a single write port. Reads are asynchronous and
// return the old contents when the same entry is written in the same cycle.
module bp_btb_array
  import bp_pkg::*;
#(
  parameter  int ENTRIES  = 64,
  localparam int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output btb_entry_t          rd_entry,
  input  logic [IDX_BITS-1:0] lk_idx,
  output btb_entry_t          lk_entry,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  btb_entry_t          wr_entry
);

  logic [ENTRIES-1:0]     valid_q;
  logic [BP_TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [BP_XLEN-1:0]     target_q [ENTRIES];

  // Valid bits clear on reset; reset also blocks any write in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
    end
  end

  // Tag and target payload; contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      tag_q[wr_idx]    <= wr_entry.tag;
      target_q[wr_idx] <= wr_entry.target;
    end
  end

  // Asynchronous reads for the fetch and resolution lookups.
  always_comb begin
    rd_entry.valid  = valid_q[rd_idx];
    rd_entry.tag    = tag_q[rd_idx];
    rd_entry.target = target_q[rd_idx];
    lk_entry.valid  = valid_q[lk_idx];
    lk_entry.tag    = tag_q[lk_idx];
    lk_entry.target = target_q[lk_idx];
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Prediction is combinational from pc_fetch; resolution updates come from ID
// carrying the counter snapshot and index produced at fetch time.
// Optional macro BP_GSHARE_EN: XORs a non-speculative global history into the
// counter index and exposes the history on predict_ghr.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter  int XLEN     = BP_XLEN,
  parameter  int ENTRIES  = 64,
  parameter  int TAG_BITS = BP_TAG_BITS,
  parameter  int CTR_BITS = 2,
  localparam int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc_fetch,
  output logic                predict_taken,
  output logic [XLEN-1:0]     predict_target,
  output logic                predict_hit,
  output logic [CTR_BITS-1:0] predict_state,
  output logic [IDX_BITS-1:0] predict_idx,
  input  logic                update_en,
  input  logic [XLEN-1:0]     update_pc,
  input  logic                update_taken,
  input  logic [XLEN-1:0]     update_target,
  input  logic [CTR_BITS-1:0] update_state,
  input  logic [IDX_BITS-1:0] update_idx
`ifdef BP_GSHARE_EN
  ,
  output logic [IDX_BITS-1:0] predict_ghr
`endif
);

  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(ctr_wnt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] WT  = CTR_BITS'(ctr_wt(CTR_BITS));

  logic [IDX_BITS-1:0] fetch_bidx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic [IDX_BITS-1:0] upd_bidx;
  logic [TAG_BITS-1:0] upd_tag;
  logic [IDX_BITS-1:0] ctr_idx;

  btb_entry_t fetch_entry;
  btb_entry_t upd_entry;
  btb_entry_t wr_entry;
  logic       wr_en;
  logic       upd_hit;

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic                ctr_wr_en;
  logic [CTR_BITS-1:0] ctr_wr_val;

  assign fetch_bidx = pc_fetch[IDX_BITS+1:2];
  assign fetch_tag  = pc_fetch[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign upd_bidx   = update_pc[IDX_BITS+1:2];
  assign upd_tag    = update_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q;

  // Global history shifts in each resolved outcome; never speculative.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (update_en) begin
      ghr_q <= (ghr_q << 1) | IDX_BITS'(update_taken);
    end
  end

  assign ctr_idx     = fetch_bidx ^ ghr_q;
  assign predict_ghr = ghr_q;
`else
  assign ctr_idx = fetch_bidx;
`endif

  bp_btb_array #(
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fetch_bidx),
    .rd_entry (fetch_entry),
    .lk_idx   (upd_bidx),
    .lk_entry (upd_entry),
    .wr_en    (wr_en),
    .wr_idx   (upd_bidx),
    .wr_entry (wr_entry)
  );

  // Fetch-side prediction; a miss reports weakly-not-taken as its snapshot.
  always_comb begin
    predict_hit    = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
    predict_idx    = ctr_idx;
    predict_state  = predict_hit ? ctr_q[ctr_idx] : WNT;
    predict_taken  = predict_hit && predict_state[CTR_BITS-1];
    predict_target = fetch_entry.target;
  end

  // Resolution decode: train on a hit, allocate on a taken miss, else ignore.
  always_comb begin
    upd_hit         = upd_entry.valid && (upd_entry.tag == upd_tag);
    wr_en           = 1'b0;
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = upd_tag;
    wr_entry.target = update_target;
    ctr_wr_en       = 1'b0;
    ctr_wr_val      = update_taken ? CTR_BITS'(sat_inc(32'(update_state), CTR_BITS))
                                   : CTR_BITS'(sat_dec(32'(update_state), CTR_BITS));
    if (update_en) begin
      if (upd_hit) begin
        ctr_wr_en = 1'b1;
        wr_en     = update_taken;
      end else if (update_taken) begin
        wr_en      = 1'b1;
        ctr_wr_en  = 1'b1;
        ctr_wr_val = WT;
      end
    end
  end

  // Counter table: reset to weakly-not-taken, written at the carried index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (ctr_wr_en) begin
      ctr_q[update_idx] <= ctr_wr_val;
    end
  end

  // PC bits outside the index/tag fields and the looked-up target are not needed.
  logic unused_bits;
  assign unused_bits = ^{pc_fetch, update_pc, upd_entry.target};

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios with
// literal expectations, then randomized traffic compared every cycle against
// a table-level model. Define BP_GSHARE_EN to exercise the history variant.
module tb_branch_predictor_btb;

  localparam int XLEN     = 32;
  localparam int ENTRIES  = 64;
  localparam int TAG_BITS = 10;
  localparam int CTR_BITS = 2;
  localparam int IDX_BITS = 6;
  localparam int unsigned CMAX = 3;
  localparam int unsigned WNT  = 1;
  localparam int unsigned WT   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [XLEN-1:0]     pc_fetch = '0;
  logic                predict_taken;
  logic [XLEN-1:0]     predict_target;
  logic                predict_hit;
  logic [CTR_BITS-1:0] predict_state;
  logic [IDX_BITS-1:0] predict_idx;
  logic                update_en = 1'b0;
  logic [XLEN-1:0]     update_pc = '0;
  logic                update_taken = 1'b0;
  logic [XLEN-1:0]     update_target = '0;
  logic [CTR_BITS-1:0] update_state = '0;
  logic [IDX_BITS-1:0] update_idx = '0;
`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] predict_ghr;
`endif

  always #5 clk = ~clk;

  branch_predictor_btb #(
    .XLEN     (XLEN),
    .ENTRIES  (ENTRIES),
    .TAG_BITS (TAG_BITS),
    .CTR_BITS (CTR_BITS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_fetch       (pc_fetch),
    .predict_taken  (predict_taken),
    .predict_target (predict_target),
    .predict_hit    (predict_hit),
    .predict_state  (predict_state),
    .predict_idx    (predict_idx),
    .update_en      (update_en),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_target  (update_target),
    .update_state   (update_state),
    .update_idx     (update_idx)
`ifdef BP_GSHARE_EN
    ,
    .predict_ghr    (predict_ghr)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: plain per-index tables and a history integer.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  int unsigned m_target [ENTRIES];
  int unsigned m_ctr    [ENTRIES];
  int unsigned m_ghr = 0;
  bit          model_ready = 1'b0;

  function automatic int unsigned f_idx(input int unsigned pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned f_tag(input int unsigned pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_BITS);
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    return m_valid[f_idx(pc)] && (m_tag[f_idx(pc)] == f_tag(pc));
  endfunction

  function automatic int unsigned m_pidx(input int unsigned pc);
`ifdef BP_GSHARE_EN
    return f_idx(pc) ^ m_ghr;
`else
    return f_idx(pc);
`endif
  endfunction

  function automatic int unsigned m_state(input int unsigned pc);
    return m_hit(pc) ? m_ctr[m_pidx(pc)] : WNT;
  endfunction

  function automatic int unsigned m_inc(input int unsigned v);
    return (v == CMAX) ? CMAX : v + 1;
  endfunction

  function automatic int unsigned m_dec(input int unsigned v);
    return (v == 0) ? 0 : v - 1;
  endfunction

  task automatic checkOutput(input string name, input longint unsigned act,
                             input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model update on each clock, following the table-level rules.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] <= 1'b0;
        m_ctr[i]   <= WNT;
      end
      m_ghr       <= 0;
      model_ready <= 1'b1;
    end else if (update_en) begin
      if (m_hit(update_pc)) begin
        m_ctr[update_idx] <= update_taken ? m_inc(update_state) : m_dec(update_state);
        if (update_taken) m_target[f_idx(update_pc)] <= update_target;
      end else if (update_taken) begin
        m_valid[f_idx(update_pc)]  <= 1'b1;
        m_tag[f_idx(update_pc)]    <= f_tag(update_pc);
        m_target[f_idx(update_pc)] <= update_target;
        m_ctr[update_idx]          <= WT;
      end
      m_ghr <= ((m_ghr * 2) + update_taken) % ENTRIES;
    end
  end

  // Every-cycle comparison of all prediction outputs against the model.
  always @(negedge clk) begin
    if (model_ready && !rst) begin
      checkOutput("hit", predict_hit, m_hit(pc_fetch));
      checkOutput("idx", predict_idx, m_pidx(pc_fetch));
      checkOutput("state", predict_state, m_state(pc_fetch));
      checkOutput("taken", predict_taken, m_hit(pc_fetch) && (m_state(pc_fetch) >= WT));
      if (m_hit(pc_fetch)) checkOutput("target", predict_target, m_target[f_idx(pc_fetch)]);
`ifdef BP_GSHARE_EN
      checkOutput("ghr", predict_ghr, m_ghr);
`endif
    end
  end

  // Drive one cycle of inputs just after the edge, return at the following negedge.
  task automatic applyStimulus(input bit r, input logic [XLEN-1:0] pcf, input bit en,
                               input logic [XLEN-1:0] upc, input bit tk,
                               input logic [XLEN-1:0] tgt, input int unsigned st,
                               input int unsigned ix);
    @(posedge clk);
    #1;
    rst           = r;
    pc_fetch      = pcf;
    update_en     = en;
    update_pc     = upc;
    update_taken  = tk;
    update_target = tgt;
    update_state  = CTR_BITS'(st);
    update_idx    = IDX_BITS'(ix);
    @(negedge clk);
  endtask

  function automatic logic [XLEN-1:0] rand_pc();
    return ($urandom & 32'hFFFC_0000) | ($urandom_range(0, 3) << 8) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);

    // Fresh table: miss, weakly-not-taken snapshot, index 0.
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_hit", predict_hit, 0);
    checkOutput("rst_taken", predict_taken, 0);
    checkOutput("rst_state", predict_state, 1);
    checkOutput("rst_idx", predict_idx, 0);

`ifdef BP_GSHARE_EN
    // Three taken resolutions build history 000111.
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h180, 1, 0);
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h180, 2, 0);
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h180, 3, 0);
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("gs_ghr", predict_ghr, 7);
    checkOutput("gs_idx", predict_idx, 7);
    checkOutput("gs_hit", predict_hit, 1);
    checkOutput("gs_state", predict_state, 1);
    // Not-taken miss only shifts history; BTB untouched.
    applyStimulus(0, 32'h100, 1, 32'h300, 0, 32'h380, 3, 7);
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("gs_ghr2", predict_ghr, 14);
    checkOutput("gs_hit2", predict_hit, 1);
    checkOutput("gs_idx2", predict_idx, 14);
`else
    // Allocation: visible the cycle after the write.
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h180, 1, 0);
    checkOutput("alloc_same_cycle_hit", predict_hit, 0);
    applyStimulus(0, 32'h100, 1, 32'h100, 0, 32'hDEAD0, 2, 0);
    checkOutput("alloc_hit", predict_hit, 1);
    checkOutput("alloc_taken", predict_taken, 1);
    checkOutput("alloc_target", predict_target, 32'h180);
    checkOutput("alloc_state", predict_state, 2);
    // Training down to the floor and back up to the ceiling.
    applyStimulus(0, 32'h100, 1, 32'h100, 0, 32'hDEAD0, 1, 0);
    checkOutput("dec_state", predict_state, 1);
    checkOutput("dec_taken", predict_taken, 0);
    checkOutput("nt_keeps_target", predict_target, 32'h180);
    applyStimulus(0, 32'h100, 1, 32'h100, 0, 32'hDEAD0, 0, 0);
    checkOutput("dec2_state", predict_state, 0);
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h180, 0, 0);
    checkOutput("sat_low_state", predict_state, 0);
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h180, 1, 0);
    checkOutput("inc1_state", predict_state, 1);
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h180, 2, 0);
    checkOutput("inc2_state", predict_state, 2);
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 32'h1C0, 3, 0);
    checkOutput("inc3_state", predict_state, 3);
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_high_state", predict_state, 3);
    checkOutput("taken_new_target", predict_target, 32'h1C0);
    // Alias at the same index with a different tag evicts the old entry.
    applyStimulus(0, 32'h100, 1, 32'h200, 1, 32'h280, 0, 0);
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("alias_old_hit", predict_hit, 0);
    applyStimulus(0, 32'h200, 0, 0, 0, 0, 0, 0);
    checkOutput("alias_new_hit", predict_hit, 1);
    checkOutput("alias_new_target", predict_target, 32'h280);
    checkOutput("alias_new_state", predict_state, 2);
    // Same-cycle read of an entry being allocated sees the old contents.
    applyStimulus(0, 32'h40, 1, 32'h40, 1, 32'h4C0, 0, 16);
    checkOutput("rw_same_hit", predict_hit, 0);
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, 0);
    checkOutput("rw_next_hit", predict_hit, 1);
    checkOutput("rw_next_target", predict_target, 32'h4C0);
    // Reset wins over a simultaneous update.
    applyStimulus(1, 32'h80, 1, 32'h80, 1, 32'h8C0, 0, 32);
    applyStimulus(0, 32'h80, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_upd_hit", predict_hit, 0);
    checkOutput("rst_upd_state", predict_state, 1);
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_clears_hit", predict_hit, 0);
`endif

    // Randomized traffic over a small index/tag pool to force hits and aliasing.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 149) == 0, rand_pc(), 1'($urandom_range(0, 1)),
                    rand_pc(), 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 7));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
